// File: rtl/char_rx_handshake_ctrl.sv
// char_rx_handshake_ctrl
//   Buffers characters from the serial receiver in a small circular FIFO and
//   presents them one at a time to the Nios CPU with a four-phase handshake.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | nothing presented; waiting for data with ack_in released
//   S_PRESENT | head entry on char_data, char_received=1; waiting for ack
//   S_RELEASE | entry popped; waiting for the CPU to drop ack_in
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   rx_valid       one-cycle strobe, rx_data holds a new character
//   rx_data        received character
//   ack_in         CPU acknowledge level (output PIO bit)
//   clear_overflow one-cycle pulse clearing the sticky overflow flag
//   char_received  head character valid (CharacterReceived PIO)
//   char_data      presented character, stable while char_received=1
//   overflow       sticky flag: a character was dropped on a full FIFO
//   fifo_level     stored entries including the presented one
module char_rx_handshake_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              ack_in,
  input  logic              clear_overflow,
  output logic              char_received,
  output logic [DATA_W-1:0] char_data,
  output logic              overflow,
  output logic [ADDR_W:0]   fifo_level
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  state_t              state, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic                char_received_d;
  logic [DATA_W-1:0]   char_data_d;
  logic                pop, push, drop, full;

  assign full = (fifo_level == FULL_LVL);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push = rx_valid && (!full || pop);
  assign drop = rx_valid && full && !pop;

  always_comb begin
    state_d         = state;
    char_received_d = char_received;
    char_data_d     = char_data;
    pop             = 1'b0;
    case (state)
      S_IDLE: begin
        char_received_d = 1'b0;
        if (!ack_in && fifo_level != '0) begin
          char_data_d     = mem[rd_ptr];
          char_received_d = 1'b1;
          state_d         = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ack_in) begin
          pop             = 1'b1;
          char_received_d = 1'b0;
          state_d         = S_RELEASE;
        end
      end
      S_RELEASE: begin
        char_received_d = 1'b0;
        if (!ack_in) state_d = S_IDLE;
      end
      default: begin
        char_received_d = 1'b0;
        state_d         = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      char_received <= 1'b0;
      char_data     <= '0;
      overflow      <= 1'b0;
      fifo_level    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      state         <= state_d;
      char_received <= char_received_d;
      char_data     <= char_data_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      // A drop wins over a simultaneous clear so no loss goes unreported.
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: the level counter marks which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_char_rx_handshake_ctrl.sv
module tb_char_rx_handshake_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       ack_in = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       char_received;
  logic [7:0] char_data;
  logic       overflow;
  logic [2:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb_q[$];
  logic       prev_cr = 1'b0;
  logic [7:0] held_data = '0;
  int         low_cnt = 100;

  char_rx_handshake_ctrl #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .ack_in         (ack_in),
    .clear_overflow (clear_overflow),
    .char_received  (char_received),
    .char_data      (char_data),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: each new presentation must match the oldest expected
  // character, stay stable while presented, and follow a low gap of >= 2 cycles.
  always @(negedge clk) begin
    if (reset_n) begin
      if (char_received && !prev_cr) begin
        chk("gap_low_ge2", 32'(low_cnt >= 2), 32'd1);
        if (sb_q.size() == 0) chk("sb_unexpected_char", {24'd0, char_data}, 32'hFFFF_FFFF);
        else chk("sb_char_order", {24'd0, char_data}, {24'd0, sb_q.pop_front()});
        held_data = char_data;
      end else if (char_received && prev_cr) begin
        chk("data_stable", {24'd0, char_data}, {24'd0, held_data});
      end
      low_cnt = char_received ? 0 : low_cnt + 1;
      prev_cr = char_received;
    end else begin
      prev_cr = 1'b0;
      low_cnt = 100;
    end
  end

  task automatic send(input logic [7:0] d, input bit accept);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = d;
    if (accept) sb_q.push_back(d);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_present(input string tag);
    int cyc = 0;
    while (!char_received && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!char_received) chk(tag, 32'd0, 32'd1);
  endtask

  // Full four-phase handshake on whatever is presented; ack held 3 cycles.
  task automatic ack_char(input string tag);
    wait_present(tag);
    @(negedge clk);
    ack_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cr_low_while_ack", 32'(char_received), 32'd0);
    end
    ack_in = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cr",    32'(char_received), 32'd0);
    chk("rst_data",  32'(char_data),     32'd0);
    chk("rst_ovf",   32'(overflow),      32'd0);
    chk("rst_level", 32'(fifo_level),    32'd0);
    reset_n = 1'b1;

    // 1: first character latency
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h41; sb_q.push_back(8'h41);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("t1_cr_after_e0", 32'(char_received), 32'd0);
    chk("t1_level",       32'(fifo_level),    32'd1);
    @(negedge clk);
    chk("t1_cr_after_e1", 32'(char_received), 32'd1);
    chk("t1_data",        32'(char_data),     32'h41);

    // 2: ack for 3 cycles, no re-presentation
    ack_in = 1'b1;
    @(negedge clk);
    chk("t2_cr_after_ack", 32'(char_received), 32'd0);
    chk("t2_level",        32'(fifo_level),    32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("t2_cr_ack_high", 32'(char_received), 32'd0);
    end
    ack_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_cr_idle", 32'(char_received), 32'd0);

    // 3: back-to-back pushes, in-order presentation with pointer wrap
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = 8'h10 + 8'(i); sb_q.push_back(8'h10 + 8'(i));
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("t3_level_full", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 4; i++) ack_char("t3_timeout");
    repeat (4) @(negedge clk);
    chk("t3_level_empty", 32'(fifo_level), 32'd0);
    chk("t3_sb_empty",    32'(sb_q.size()), 32'd0);

    // 4: overflow on full FIFO, clear, drop+clear priority
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b1);
    repeat (2) @(negedge clk);
    send(8'h55, 1'b0);
    chk("t4_ovf_set", 32'(overflow),   32'd1);
    chk("t4_level",   32'(fifo_level), 32'd4);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    rx_valid = 1'b1; rx_data = 8'h56; clear_overflow = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; clear_overflow = 1'b0;
    chk("t4_drop_beats_clear", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("t4_ovf_clr2", 32'(overflow), 32'd0);

    // 5: push while full in the same cycle as the ack rise
    wait_present("t5_timeout");
    ack_in = 1'b1; rx_valid = 1'b1; rx_data = 8'h66; sb_q.push_back(8'h66);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("t5_level", 32'(fifo_level),    32'd4);
    chk("t5_ovf",   32'(overflow),      32'd0);
    chk("t5_cr",    32'(char_received), 32'd0);
    @(negedge clk);
    ack_in = 1'b0;
    for (int i = 0; i < 4; i++) ack_char("t5_timeout");
    repeat (4) @(negedge clk);
    chk("t5_level_empty", 32'(fifo_level), 32'd0);
    chk("t5_sb_empty",    32'(sb_q.size()), 32'd0);

    // 6: reset in the middle of a presentation with 3 entries stored
    for (int i = 0; i < 3; i++) send(8'h30 + 8'(i), 1'b1);
    wait_present("t6_timeout");
    @(negedge clk);
    chk("t6_level_pre", 32'(fifo_level), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_cr",    32'(char_received), 32'd0);
    chk("t6_rst_data",  32'(char_data),     32'd0);
    chk("t6_rst_ovf",   32'(overflow),      32'd0);
    chk("t6_rst_level", 32'(fifo_level),    32'd0);
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h77, 1'b1);
    chk("t6_level_new", 32'(fifo_level), 32'd1);
    ack_char("t6_timeout");
    repeat (4) @(negedge clk);
    chk("t6_level_empty", 32'(fifo_level), 32'd0);
    chk("t6_sb_empty",    32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
